// File: rtl/arb_pkg.sv
// Shared definitions for the two-master 8-bit Wishbone arbiter.
// State encoding doubles as the grant; the grant index constants select O_grant bits.
package arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGnt0 = 2'd1,
      StGnt1 = 2'd2
   } arb_state_e;

   localparam logic [7:0]  TimeoutData = 8'hFF;
   localparam int unsigned GntM0       = 0;
   localparam int unsigned GntM1       = 1;

endpackage

// File: rtl/wb8_arb_timeout.sv
// Stalled-strobe watchdog: counts unacknowledged strobe cycles and forces a terminating ACK.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module wb8_arb_timeout
   import arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stb_i,
   input  logic ack_i,
   input  logic grant_chg_i,
   output logic force_ack_o,
   output logic timeout_o
);

   localparam logic [7:0] Limit = 8'(TIMEOUT_CYCLES);

   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= 8'h00;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      force_ack_o = stb_i && (cnt_q == Limit);
      cnt_d       = cnt_q;
      timeout_d   = timeout_q | force_ack_o;
      // A forced termination restarts the count just like a real slave ACK.
      if (ack_i || grant_chg_i || force_ack_o) begin
         cnt_d = 8'h00;
      end else if (stb_i) begin
         cnt_d = cnt_q + 8'h01;
      end
   end

   assign timeout_o = timeout_q;

   // The data substituted on a forced ACK lives in the top-level read mux.
   logic unused_pkg;
   assign unused_pkg = ^TimeoutData;

endmodule

// File: rtl/wb8_arbiter2.sv
// Round-robin arbiter letting the CPU (M0) and a second master (M1) share one Wishbone slave port.
// Optional stalled-strobe timeout enabled with `define ARB_TIMEOUT_EN.
module wb8_arbiter2
   import arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADRBITS        = 32
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic               M0_CYC_I,
   input  logic               M0_STB_I,
   input  logic               M0_WE_I,
   input  logic [ADRBITS-1:0] M0_ADR_I,
   input  logic [7:0]         M0_DAT_I,
   output logic [7:0]         M0_DAT_O,
   output logic               M0_ACK_O,
   input  logic               M1_CYC_I,
   input  logic               M1_STB_I,
   input  logic               M1_WE_I,
   input  logic [ADRBITS-1:0] M1_ADR_I,
   input  logic [7:0]         M1_DAT_I,
   output logic [7:0]         M1_DAT_O,
   output logic               M1_ACK_O,
   output logic               S_CYC_O,
   output logic               S_STB_O,
   output logic               S_WE_O,
   output logic [ADRBITS-1:0] S_ADR_O,
   output logic [7:0]         S_DAT_O,
   input  logic [7:0]         S_DAT_I,
   input  logic               S_ACK_I,
   output logic [1:0]         O_grant,
   output logic               O_timeout
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 2..255");
   end

   arb_state_e state_q, state_d;
   logic       last_m1_q, last_m1_d;
   logic       gnt0, gnt1;
   logic       force_ack;
   logic [7:0] rd_data;

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q   <= StIdle;
         last_m1_q <= 1'b1;  // M0 wins the first contention
      end else begin
         state_q   <= state_d;
         last_m1_q <= last_m1_d;
      end
   end

   // The owner keeps the bus for its whole CYC tenure; a waiting master takes over without idling.
   always_comb begin
      state_d   = state_q;
      last_m1_d = last_m1_q;
      unique case (state_q)
         StIdle: begin
            if (M0_CYC_I && M1_CYC_I) begin
               state_d = last_m1_q ? StGnt0 : StGnt1;
            end else if (M0_CYC_I) begin
               state_d = StGnt0;
            end else if (M1_CYC_I) begin
               state_d = StGnt1;
            end
         end
         StGnt0: begin
            if (!M0_CYC_I) begin
               last_m1_d = 1'b0;
               state_d   = M1_CYC_I ? StGnt1 : StIdle;
            end
         end
         StGnt1: begin
            if (!M1_CYC_I) begin
               last_m1_d = 1'b1;
               state_d   = M0_CYC_I ? StGnt0 : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign gnt0 = (state_q == StGnt0);
   assign gnt1 = (state_q == StGnt1);

   always_comb begin
      O_grant        = 2'b00;
      O_grant[GntM0] = gnt0;
      O_grant[GntM1] = gnt1;
      S_CYC_O        = 1'b0;
      S_STB_O        = 1'b0;
      S_WE_O         = 1'b0;
      S_ADR_O        = '0;
      S_DAT_O        = 8'h00;
      if (gnt0) begin
         S_CYC_O = M0_CYC_I;
         S_STB_O = M0_STB_I;
         S_WE_O  = M0_WE_I;
         S_ADR_O = M0_ADR_I;
         S_DAT_O = M0_DAT_I;
      end else if (gnt1) begin
         S_CYC_O = M1_CYC_I;
         S_STB_O = M1_STB_I;
         S_WE_O  = M1_WE_I;
         S_ADR_O = M1_ADR_I;
         S_DAT_O = M1_DAT_I;
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic grant_chg;
   assign grant_chg = (state_d != state_q);

   wb8_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i      (CLK_I),
      .rst_ni     (RST_I),
      .stb_i      (S_STB_O),
      .ack_i      (S_ACK_I),
      .grant_chg_i(grant_chg),
      .force_ack_o(force_ack),
      .timeout_o  (O_timeout)
   );
`else
   assign force_ack = 1'b0;
   assign O_timeout = 1'b0;
`endif

   // A forced ACK overrides the slave and returns the timeout marker byte.
   assign rd_data  = force_ack ? TimeoutData : S_DAT_I;
   assign M0_ACK_O = gnt0 & M0_STB_I & (S_ACK_I | force_ack);
   assign M1_ACK_O = gnt1 & M1_STB_I & (S_ACK_I | force_ack);
   assign M0_DAT_O = M0_ACK_O ? rd_data : 8'h00;
   assign M1_DAT_O = M1_ACK_O ? rd_data : 8'h00;

endmodule

// File: tb/tb_wb8_arbiter2.sv
// Self-checking bench for wb8_arbiter2: directed scenarios plus randomized traffic against a
// behavioural grant model. Timeout expectations follow ARB_TIMEOUT_EN.
module tb_wb8_arbiter2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we, m0_ack;
   logic [31:0] m0_adr;
   logic [7:0]  m0_wdat, m0_rdat;
   logic        m1_cyc, m1_stb, m1_we, m1_ack;
   logic [31:0] m1_adr;
   logic [7:0]  m1_wdat, m1_rdat;
   logic        s_cyc, s_stb, s_we, s_ack;
   logic [31:0] s_adr;
   logic [7:0]  s_wdat, s_rdat;
   logic [1:0]  grant;
   logic        timeout;

   int   errors = 0;
   int   checks = 0;
   logic exp_to = 1'b0;

   always #5 clk = ~clk;

   wb8_arbiter2 #(
      .TIMEOUT_CYCLES(8),
      .ADRBITS       (32)
   ) dut (
      .CLK_I    (clk),
      .RST_I    (rst_n),
      .M0_CYC_I (m0_cyc),
      .M0_STB_I (m0_stb),
      .M0_WE_I  (m0_we),
      .M0_ADR_I (m0_adr),
      .M0_DAT_I (m0_wdat),
      .M0_DAT_O (m0_rdat),
      .M0_ACK_O (m0_ack),
      .M1_CYC_I (m1_cyc),
      .M1_STB_I (m1_stb),
      .M1_WE_I  (m1_we),
      .M1_ADR_I (m1_adr),
      .M1_DAT_I (m1_wdat),
      .M1_DAT_O (m1_rdat),
      .M1_ACK_O (m1_ack),
      .S_CYC_O  (s_cyc),
      .S_STB_O  (s_stb),
      .S_WE_O   (s_we),
      .S_ADR_O  (s_adr),
      .S_DAT_O  (s_wdat),
      .S_DAT_I  (s_rdat),
      .S_ACK_I  (s_ack),
      .O_grant  (grant),
      .O_timeout(timeout)
   );

   task automatic idle_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0;
      s_ack = 0; s_rdat = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h1234; m0_wdat = 8'h11;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h5678; m1_wdat = 8'h22;
      s_ack = 1; s_rdat = 8'hA5;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({grant, s_cyc, s_stb, s_we, s_adr, s_wdat} !== '0)
         $display("FAIL reset_bus got=%h required=0", {grant, s_cyc, s_stb, s_we, s_adr, s_wdat});
      checks++;
      if ({m0_ack, m1_ack, m0_rdat, m1_rdat, timeout} !== '0) begin
         errors++;
         $display("FAIL reset_ack got=%h required=0", {m0_ack, m1_ack, m0_rdat, m1_rdat, timeout});
      end
      if ({grant, s_cyc, s_stb, s_we, s_adr, s_wdat} !== '0) errors++;
      rst_n = 1;
      #1;
      checks++;
      if (grant !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_grant got=%b required=00", grant);
      end
      @(negedge clk);
      #1;
      checks++;
      if (grant !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_grant got=%b required=01", grant);
      end
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int acks = 0;
      m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h10;
      #1;
      checks++;
      if (s_stb !== 1'b0) begin
         errors++;
         $display("FAIL single_latency got=%b required=0", s_stb);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s_ack  = (i == 2);
         s_rdat = (i == 2) ? 8'h5A : 8'h00;
         if (i == 3) begin
            m1_cyc = 0; m1_stb = 0;
         end
         #1;
         if (i == 0) begin
            checks++;
            if ({grant, s_cyc, s_stb, s_we, s_adr} !== {2'b10, 3'b110, 32'h10}) begin
               errors++;
               $display("FAIL single_bus got=%h required=%h", {grant, s_cyc, s_stb, s_we, s_adr},
                        {2'b10, 3'b110, 32'h10});
            end
         end
         checks++;
         if (m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_m0_ack cyc=%0d got=%b required=0", i, m0_ack);
         end
         if (m1_ack === 1'b1) begin
            acks++;
            checks++;
            if (m1_rdat !== 8'h5A) begin
               errors++;
               $display("FAIL single_data got=%h required=5a", m1_rdat);
            end
         end
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL single_ack_count got=%0d required=1", acks);
      end
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit         c0 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      bit         c1 [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      logic [1:0] g  [10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      logic       ea0, ea1;
      for (int i = 0; i < 10; i++) begin
         m0_cyc = c0[i]; m0_stb = c0[i]; m0_adr = 32'h100 + 32'(i);
         m1_cyc = c1[i]; m1_stb = c1[i]; m1_adr = 32'h200 + 32'(i);
         s_ack = 1; s_rdat = 8'h30 + 8'(i);
         #1;
         ea0 = (g[i] == 2'b01) && c0[i];
         ea1 = (g[i] == 2'b10) && c1[i];
         checks++;
         if (grant !== g[i]) begin
            errors++;
            $display("FAIL rr_grant cyc=%0d got=%b required=%b", i, grant, g[i]);
         end
         checks++;
         if ({m0_ack, m0_rdat, m1_ack, m1_rdat} !==
             {ea0, ea0 ? s_rdat : 8'h00, ea1, ea1 ? s_rdat : 8'h00}) begin
            errors++;
            $display("FAIL rr_ack cyc=%0d got=%h required=%h", i, {m0_ack, m0_rdat, m1_ack, m1_rdat},
                     {ea0, ea0 ? s_rdat : 8'h00, ea1, ea1 ? s_rdat : 8'h00});
         end
         @(negedge clk);
      end
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_lock();
      logic [1:0]  g [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      logic [31:0] exp_adr;
      for (int i = 0; i < 7; i++) begin
         m0_cyc = (i < 5); m0_stb = (i < 5); m0_adr = 32'h300 + 32'(i);
         m1_cyc = (i >= 1); m1_stb = (i >= 1); m1_adr = 32'hBEEF;
         s_ack = 1; s_rdat = 8'h44;
         #1;
         exp_adr = (g[i] == 2'b01) ? m0_adr : (g[i] == 2'b10) ? 32'hBEEF : 32'h0;
         checks++;
         if ({grant, s_adr} !== {g[i], exp_adr}) begin
            errors++;
            $display("FAIL lock_grant cyc=%0d got=%b/%h required=%b/%h", i, grant, s_adr, g[i], exp_adr);
         end
         checks++;
         if (m1_ack !== (g[i] == 2'b10)) begin
            errors++;
            $display("FAIL lock_m1_ack cyc=%0d got=%b required=%b", i, m1_ack, g[i] == 2'b10);
         end
         @(negedge clk);
      end
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic       ea, eto;
      logic [7:0] ed;
      for (int i = 0; i < 13; i++) begin
         m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
         s_ack = 0; s_rdat = 8'h77;
         #1;
`ifdef ARB_TIMEOUT_EN
         ea  = (i == 9);
         ed  = (i == 9) ? 8'hFF : 8'h00;
         eto = (i >= 10);
`else
         ea  = 1'b0;
         ed  = 8'h00;
         eto = 1'b0;
`endif
         checks++;
         if ({m0_ack, m0_rdat, timeout} !== {ea, ed, eto}) begin
            errors++;
            $display("FAIL timeout cyc=%0d got=%b/%h/%b required=%b/%h/%b", i, m0_ack, m0_rdat,
                     timeout, ea, ed, eto);
         end
         @(negedge clk);
      end
`ifdef ARB_TIMEOUT_EN
      exp_to = 1'b1;
`endif
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if (timeout !== exp_to) begin
         errors++;
         $display("FAIL timeout_sticky got=%b required=%b", timeout, exp_to);
      end
   endtask

   task automatic test_random();
      int          owner   = -1;  // -1 idle, else master index
      bit          last_m1 = 1;
      int          run     = 0;
      logic [1:0]  eg;
      logic [42:0] eb;
      logic        ea0, ea1, own_cyc, oth_cyc;
      idle_inputs();
      rst_n = 0;
      #2;
      rst_n = 1;
      exp_to = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         m0_cyc  = m0_cyc ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
         m0_stb  = m0_cyc ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
         m0_we   = 1'($urandom_range(1)); m0_adr = $urandom; m0_wdat = 8'($urandom);
         m1_cyc  = m1_cyc ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
         m1_stb  = m1_cyc ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
         m1_we   = 1'($urandom_range(1)); m1_adr = $urandom; m1_wdat = 8'($urandom);
         // Keep slave stalls well short of the timeout limit.
         s_ack   = (run >= 3) ? 1'b1 : 1'($urandom_range(1));
         s_rdat  = 8'($urandom);
         #1;
         eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
         eb  = (owner == 0) ? {m0_cyc, m0_stb, m0_we, m0_adr, m0_wdat} :
               (owner == 1) ? {m1_cyc, m1_stb, m1_we, m1_adr, m1_wdat} : '0;
         ea0 = s_ack && (owner == 0) && m0_stb;
         ea1 = s_ack && (owner == 1) && m1_stb;
         checks++;
         if ({grant, s_cyc, s_stb, s_we, s_adr, s_wdat} !== {eg, eb}) begin
            errors++;
            $display("FAIL rand_bus n=%0d got=%h required=%h", n,
                     {grant, s_cyc, s_stb, s_we, s_adr, s_wdat}, {eg, eb});
         end
         checks++;
         if ({m0_ack, m0_rdat, m1_ack, m1_rdat, timeout} !==
             {ea0, ea0 ? s_rdat : 8'h00, ea1, ea1 ? s_rdat : 8'h00, exp_to}) begin
            errors++;
            $display("FAIL rand_ack n=%0d got=%h required=%h", n,
                     {m0_ack, m0_rdat, m1_ack, m1_rdat, timeout},
                     {ea0, ea0 ? s_rdat : 8'h00, ea1, ea1 ? s_rdat : 8'h00, exp_to});
         end
         run = s_ack ? 0 : run + 1;
         if (owner < 0) begin
            if (m0_cyc && m1_cyc) owner = last_m1 ? 0 : 1;
            else if (m0_cyc)      owner = 0;
            else if (m1_cyc)      owner = 1;
         end else begin
            own_cyc = (owner == 0) ? m0_cyc : m1_cyc;
            oth_cyc = (owner == 0) ? m1_cyc : m0_cyc;
            if (!own_cyc) begin
               last_m1 = (owner == 1);
               owner   = oth_cyc ? 1 - owner : -1;
            end
         end
      end
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
      @(negedge clk);
      #1;
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL mid_pre_grant got=%b required=10", grant);
      end
      #1;
      rst_n = 0; s_ack = 1; s_rdat = 8'h5A;
      #1;
      checks++;
      if ({grant, s_cyc, s_stb, s_adr, m0_ack, m1_ack, m1_rdat, timeout} !== '0) begin
         errors++;
         $display("FAIL mid_reset_clear got=%h required=0",
                  {grant, s_cyc, s_stb, s_adr, m0_ack, m1_ack, m1_rdat, timeout});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({grant, m1_ack} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_hold cyc=%0d got=%b required=000", i, {grant, m1_ack});
         end
      end
      idle_inputs();
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb8_arbiter2.md
Name: wb8_arbiter2

Overview:
- Two-master, one-slave arbiter for the 8-bit Wishbone bus.
- Shares the downstream address-decoded slave fabric (ROM, RAM/SRAM, UART, SPI, timer, PRNG, LEDs) between the CPU (M0) and a second bus master such as a DMA or video fetcher (M1).
- Sits between the masters and the existing address decoder; the decoder sees one master-side port.
- Grants are held for a whole CYC cycle so multi-byte CPU accesses are never split.

Parameters:
- TIMEOUT_CYCLES, default 255: cycles a strobe may stay unacknowledged before forced termination (used only with the optional feature). Legal range 2..255.
- ADRBITS, default 32: address width passed through.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous, active-low reset.
- M0_CYC_I, M0_STB_I, M0_WE_I  in  1 each  master 0 bus cycle, strobe, write enable.
- M0_ADR_I  in  ADRBITS  master 0 address.
- M0_DAT_I  in  8  master 0 write data.
- M0_DAT_O  out  8  read data to master 0.
- M0_ACK_O  out  1  acknowledge to master 0.
- M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I, M1_DAT_O, M1_ACK_O: same as M0, for master 1.
- S_CYC_O, S_STB_O, S_WE_O  out  1 each  to the slave fabric.
- S_ADR_O  out  ADRBITS  address to the slave fabric.
- S_DAT_O  out  8  write data to the slave fabric.
- S_DAT_I  in  8  read data from the slave fabric.
- S_ACK_I  in  1  acknowledge from the slave fabric.
- O_grant  out  2  one-hot current grant: bit0 = M0, bit1 = M1.
- O_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (RST_I low, asynchronous):
  - state = IDLE, last_grant = M1 (so M0 wins the first contention).
  - O_grant = 00, O_timeout = 0.
  - All S_* outputs 0, all Mx_ACK_O 0, Mx_DAT_O = 0x00.
  - Asserting reset mid-transfer aborts immediately; no ACK is issued.
- States: IDLE, GNT0, GNT1. The state register is the grant; O_grant decodes the state.
- IDLE:
  - Only M0_CYC_I high -> GNT0. Only M1_CYC_I high -> GNT1.
  - Both high -> grant the master that is not last_grant (round-robin).
  - Neither -> stay in IDLE.
- GNTx:
  - Stay while Mx_CYC_I is high, regardless of the other master.
  - When Mx_CYC_I drops: if the other master's CYC is high, go directly to GNTy (no idle cycle); otherwise go to IDLE.
  - last_grant <= x whenever GNTx is left.
- Arbitration latency: the first S_STB_O appears 1 clock after CYC rises in IDLE. A handover costs 1 clock.
- Muxing (combinational from state):
  - In GNTx, S_CYC_O/S_STB_O/S_WE_O/S_ADR_O/S_DAT_O = master x signals.
  - In IDLE, all S_* outputs = 0.
- Acknowledge:
  - Mx_ACK_O = S_ACK_I & (state == GNTx) & Mx_STB_I.
  - The non-granted master always sees ACK 0.
  - M0_DAT_O and M1_DAT_O are both driven from S_DAT_I; they are qualified by ACK only.
- Protocol rules:
  - STB without CYC is ignored.
  - A master may hold CYC across many STB/ACK beats; the grant persists for all of them.
  - Worst-case wait for a requester = one full CYC tenure of the other master + 1 clock.
- Simultaneous events: CYC drop by the owner and a new request in the same cycle resolve by round-robin on the next edge.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter increments each clock in which S_STB_O=1 and S_ACK_I=0.
  - The counter clears on S_ACK_I, on any grant change, and on reset.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter drives Mx_ACK_O=1 for one cycle with Mx_DAT_O=0xFF (the slave ACK is ignored that cycle), sets O_timeout=1 (sticky until reset), and clears the counter.
- Disabled: no counter, O_timeout tied to 0, ACK purely from the slave.

Decomposition:
- Shared package arb_pkg: state encodings IDLE=2'd0, GNT0=2'd1, GNT1=2'd2; constant TIMEOUT_DATA=8'hFF; grant index constants.
- One sub-module: wb8_arb_timeout (counter plus forced-ACK generator), instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset: RST_I low with both CYC high -> O_grant=00, all S_* outputs 0, both ACKs 0. Release reset -> O_grant=01 one clock later.
- Single master: M1 reads 0x000010 with the slave acking after 2 cycles with 0x5A -> S_STB_O rises at clk+1, M1_ACK_O pulses once, M1_DAT_O=0x5A, M0_ACK_O stays 0.
- Contention round-robin: both CYC held high, each master releases after 3 beats -> grants alternate 01,10,01 with handover in 1 clock and no IDLE cycle.
- Lock: M0 holds CYC for 4 beats while M1 requests -> M1 granted only on the clock after M0_CYC_I falls; the M0 beats are not interleaved.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): the slave never acks -> M0_ACK_O pulses 8 cycles after STB with M0_DAT_O=0xFF and O_timeout latches 1. Without the macro: no ACK, O_timeout=0.
- Reset mid-transfer: RST_I low during a GNT1 wait -> outputs clear asynchronously and no ACK is seen.
